// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: canonical NOP encoding, opcode fields and the fetch FSM state type.
package fetch_unit_pkg;

  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [2:0] FUNCT3_ADDI = 3'b000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = {12'd0, 5'd0, FUNCT3_ADDI, 5'd0, OPC_OP_IMM};

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic instr_available(input fetch_state_t st, input logic rvalid);
    return ((st == WAIT) && rvalid) || (st == HOLD);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of hazard-control inputs, instruction-memory handshake and F/D outputs of the fetch stage.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            pc_en_i;
  logic            f_d_en_i;
  logic            pcsrc_i;
  logic            flush_i;
  logic [XLEN-1:0] pc_target_i;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ready_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;

  logic [31:0]     d_instr_o;
  logic [XLEN-1:0] d_pc_o;
  logic [XLEN-1:0] d_pc_plus4_o;
  logic            d_valid_o;
  logic            fetch_stall_o;

  modport master (
    input  pc_en_i, f_d_en_i, pcsrc_i, flush_i, pc_target_i,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o,
    output d_instr_o, d_pc_o, d_pc_plus4_o, d_valid_o, fetch_stall_o
  );

  modport slave (
    output pc_en_i, f_d_en_i, pcsrc_i, flush_i, pc_target_i,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o,
    input  d_instr_o, d_pc_o, d_pc_plus4_o, d_valid_o, fetch_stall_o
  );
endinterface

// File: rtl/fetch_unit_fd_pipe_reg.sv
// F/D pipeline register: flush beats load, load beats bubble, and a disabled register holds everything.
module fd_pipe_reg
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [31:0]     d_instr_o,
  output logic [XLEN-1:0] d_pc_o,
  output logic [XLEN-1:0] d_pc_plus4_o,
  output logic            d_valid_o
);

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  // Bubbles and flushes only replace the instruction; the PC fields keep their last real values.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (en_i && load_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end else if (en_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign d_instr_o    = instr_q;
  assign d_pc_o       = pc_q;
  assign d_pc_plus4_o = pc_plus4_q;
  assign d_valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request in flight and feeds F/D.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [31:0]     hold_q, hold_d;
  logic [31:0]     avail_instr;
  logic            available;
  logic            consume;

  assign pc_plus4    = pc_q + XLEN'(4);
  assign available   = instr_available(state_q, bus.imem_rvalid_i);
  assign avail_instr = (state_q == HOLD) ? hold_q : bus.imem_rdata_i;
  assign consume     = available & bus.f_d_en_i & bus.pc_en_i & ~bus.pcsrc_i & ~bus.flush_i;

  // A redirect always wins over sequential advance; a response racing a redirect is discarded.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pc_d    = pc_q;
    if (bus.pcsrc_i) begin
      pc_d = bus.pc_target_i;
    end else if (consume) begin
      pc_d = pc_plus4;
    end
    case (state_q)
      REQ: begin
        if (bus.imem_ready_i) begin
          state_d = bus.pcsrc_i ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (bus.pcsrc_i) begin
          state_d = bus.imem_rvalid_i ? REQ : DRAIN;
        end else if (bus.imem_rvalid_i) begin
          if (consume) begin
            state_d = REQ;
          end else begin
            hold_d  = bus.imem_rdata_i;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.pcsrc_i || consume) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid_i) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.imem_req_o    = (state_q == REQ) & ~rst;
  assign bus.imem_addr_o   = pc_q;
  assign bus.fetch_stall_o = ~available;

  fd_pipe_reg #(
    .XLEN(XLEN)
  ) u_fd_pipe_reg (
    .clk         (clk),
    .rst         (rst),
    .en_i        (bus.f_d_en_i),
    .flush_i     (bus.flush_i),
    .load_i      (consume),
    .instr_i     (avail_instr),
    .pc_i        (pc_q),
    .pc_plus4_i  (pc_plus4),
    .d_instr_o   (bus.d_instr_o),
    .d_pc_o      (bus.d_pc_o),
    .d_pc_plus4_o(bus.d_pc_plus4_o),
    .d_valid_o   (bus.d_valid_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder, a scoreboard of expected F/D loads and point checks.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   respDelay = 1;
  int   countdown = 0;
  logic [31:0] pendAddr = '0;
  exp_t expQ[$];

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrFor(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic pcEn, input logic fdEn, input logic pcsrc,
                               input logic flush, input logic [31:0] target, input logic ready);
    bus.pc_en_i      = pcEn;
    bus.f_d_en_i     = fdEn;
    bus.pcsrc_i      = pcsrc;
    bus.flush_i      = flush;
    bus.pc_target_i  = target;
    bus.imem_ready_i = ready;
  endtask

  task automatic expectLoad(input logic [31:0] pc, input logic [31:0] instr);
    expQ.push_back({pc, instr});
  endtask

  // Memory model: answers an accepted request respDelay cycles later.
  always begin : responder
    logic        acc;
    logic [31:0] a;
    @(posedge clk);
    acc = bus.imem_req_o && bus.imem_ready_i;
    a   = bus.imem_addr_o;
    #1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    if (acc) begin
      pendAddr  = a;
      countdown = respDelay;
    end
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = instrFor(pendAddr);
      end
    end
  end

  // With f_d_en high the register either loads or bubbles, so d_valid marks a fresh load.
  always begin : monitor
    logic en;
    logic r;
    exp_t e;
    @(posedge clk);
    en = bus.f_d_en_i;
    r  = rst;
    #1;
    if (!r && en && bus.d_valid_o) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL fd_unexpected: got load pc 0x%08h instr 0x%08h, expected no load",
                 bus.d_pc_o, bus.d_instr_o);
      end else begin
        e = expQ.pop_front();
        checkOutput("fd_pc", bus.d_pc_o, e.pc);
        checkOutput("fd_instr", bus.d_instr_o, e.instr);
        checkOutput("fd_pc_plus4", bus.d_pc_plus4_o, e.pc + 32'd4);
      end
    end
  end

  initial begin : watchdog
    #20000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : stimulus
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    respDelay = 1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_d_valid", 32'(bus.d_valid_o), 32'h0);
    checkOutput("rst_d_instr", bus.d_instr_o, 32'h0000_0013);
    checkOutput("rst_d_pc", bus.d_pc_o, 32'h0);
    checkOutput("rst_imem_req", 32'(bus.imem_req_o), 32'h0);
    rst = 1'b0;
    bus.imem_ready_i = 1'b1;
    #1;
    checkOutput("first_imem_addr", bus.imem_addr_o, 32'h0);
    checkOutput("first_imem_req", 32'(bus.imem_req_o), 32'h1);

    $display("[TB] straight-line fetch");
    expectLoad(32'h0, 32'h5A00_0003);
    expectLoad(32'h4, 32'h5A00_0007);
    expectLoad(32'h8, 32'h5A00_000B);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("stream_d_valid", 32'(bus.d_valid_o), 32'(i % 2));
      checkOutput("stream_stall", 32'(bus.fetch_stall_o), 32'(i % 2));
    end

    $display("[TB] hold buffer");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    bus.imem_ready_i = 1'b0;
    checkOutput("wait_stall", 32'(bus.fetch_stall_o), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("hold_stall", 32'(bus.fetch_stall_o), 32'h0);
      checkOutput("hold_d_pc", bus.d_pc_o, 32'h8);
      checkOutput("hold_d_instr", bus.d_instr_o, 32'h5A00_000B);
      checkOutput("hold_d_valid", 32'(bus.d_valid_o), 32'h1);
      checkOutput("hold_imem_req", 32'(bus.imem_req_o), 32'h0);
    end
    expectLoad(32'hC, 32'h5A00_000F);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("release_imem_addr", bus.imem_addr_o, 32'h10);
    checkOutput("release_imem_req", 32'(bus.imem_req_o), 32'h1);
    checkOutput("release_d_pc_plus4", bus.d_pc_plus4_o, 32'h10);

    $display("[TB] redirect with flush");
    respDelay = 2;
    bus.imem_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("redir_wait_stall", 32'(bus.fetch_stall_o), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("flush_d_instr", bus.d_instr_o, 32'h0000_0013);
    checkOutput("flush_d_valid", 32'(bus.d_valid_o), 32'h0);
    checkOutput("flush_d_pc_hold", bus.d_pc_o, 32'hC);
    checkOutput("drain_imem_req", 32'(bus.imem_req_o), 32'h0);
    @(negedge clk);
    checkOutput("redir_imem_addr", bus.imem_addr_o, 32'h0000_0100);
    checkOutput("redir_imem_req", 32'(bus.imem_req_o), 32'h1);
    respDelay = 1;
    expectLoad(32'h0000_0100, 32'h5A00_0103);
    bus.imem_ready_i = 1'b1;
    @(negedge clk);
    bus.imem_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("redir_d_pc", bus.d_pc_o, 32'h0000_0100);

    $display("[TB] memory not ready");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("nready_imem_addr", bus.imem_addr_o, 32'h0000_0104);
      checkOutput("nready_imem_req", 32'(bus.imem_req_o), 32'h1);
      checkOutput("nready_stall", 32'(bus.fetch_stall_o), 32'h1);
      checkOutput("nready_d_valid", 32'(bus.d_valid_o), 32'h0);
    end

    $display("[TB] pc wrap");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_imem_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    expectLoad(32'hFFFF_FFFC, 32'hA5FF_FFFF);
    @(negedge clk);
    bus.imem_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("wrap_next_addr", bus.imem_addr_o, 32'h0);
    checkOutput("wrap_d_pc", bus.d_pc_o, 32'hFFFF_FFFC);
    checkOutput("wrap_d_pc_plus4", bus.d_pc_plus4_o, 32'h0);

    $display("[TB] reset while waiting");
    respDelay = 3;
    bus.imem_ready_i = 1'b1;
    @(negedge clk);
    bus.imem_ready_i = 1'b0;
    checkOutput("rstwait_stall", 32'(bus.fetch_stall_o), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst2_d_valid", 32'(bus.d_valid_o), 32'h0);
    checkOutput("rst2_d_instr", bus.d_instr_o, 32'h0000_0013);
    checkOutput("rst2_d_pc", bus.d_pc_o, 32'h0);
    checkOutput("rst2_imem_req", 32'(bus.imem_req_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("late_rvalid_stall", 32'(bus.fetch_stall_o), 32'h1);
    @(negedge clk);
    checkOutput("late_imem_addr", bus.imem_addr_o, 32'h0);
    checkOutput("late_imem_req", 32'(bus.imem_req_o), 32'h1);
    checkOutput("late_d_valid", 32'(bus.d_valid_o), 32'h0);
    respDelay = 1;
    expectLoad(32'h0, 32'h5A00_0003);
    bus.imem_ready_i = 1'b1;
    @(negedge clk);
    bus.imem_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_d_pc", bus.d_pc_o, 32'h0);
    checkOutput("post_rst_d_valid", 32'(bus.d_valid_o), 32'h1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
